instruction_encoder: RTL
========================

# instruction_encoder

Packs decoded instruction fields (8-bit operation code, Rdest, Rsrc, 8-bit immediate) back into 16-bit machine words and streams them into instruction memory through a write handshake. It performs the inverse of the instruction-field decoder. It sits between the program loader/debug port and the instruction memory write port, so test programs can be built field-by-field and written sequentially. A small FIFO decouples field input from memory back-pressure.

## Interface
- ADDR_WIDTH, 8, instruction memory address width
- FIFO_DEPTH, 4, encoded-word FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  pulse: begin session at base_addr (honoured only in IDLE/DONE)
- base_addr  in  ADDR_WIDTH  first write address, sampled with start
- finish  in  1  pulse: no more fields follow (honoured only in LOAD)
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- instructionOP  in  8  {op[15:12], ext[7:4]}, same layout the decoder produces
- Rdest  in  4  destination / address / target / cond field
- Rsrc  in  4  source / link / cond field
- immediate  in  8  immediate field
- mem_we  out  1  write request, held until mem_ready
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  16  encoded instruction
- mem_ready  in  1  write completes on cycle mem_we && mem_ready
- busy  out  1  state is LOAD or DRAIN
- done  out  1  one-cycle pulse on entering DONE
- err_illegal  out  1  sticky: an unencodable bundle was accepted
- err_overflow  out  1  sticky: address space exhausted
- words_written  out  ADDR_WIDTH+1  completed memory writes this session

## Operation
- Encoding (combinational at input, word enqueued): let hi = instructionOP[7:4], ext = instructionOP[3:0].
  - hi[1:0] != 0 (immediate class): {hi, Rdest, immediate}.
  - hi == 0000 (register class): {0000, Rdest, ext, Rsrc}.
  - hi == 0100, ext[3:2] == 00 (LOAD): {0100, Rdest, ext, Rsrc}.
  - hi == 0100, ext[3:2] in 01/10/11 (STOR/JAL/Jcond): {0100, Rsrc, ext, Rdest}.
  - hi == 1100 (Bcond): {1100, Rdest, immediate}.
  - any other hi (1000): illegal; bundle handshakes normally, is not enqueued, err_illegal set.
- States: IDLE -> (start) LOAD -> (finish) DRAIN -> (FIFO empty, no write pending) DONE -> (start) LOAD.
- start: addr <= base_addr, FIFO flushed, words_written, err_illegal, err_overflow cleared.
- in_ready = (state == LOAD) && !fifo_full && !err_overflow.
- Write engine: when FIFO non-empty and no write pending, present head as mem_wdata/mem_addr, assert mem_we; on mem_ready pop, addr+1, words_written+1.
- Overflow: write completing at addr 2^ADDR_WIDTH-1 sets err_overflow; no wrap; remaining FIFO flushed; state goes to DONE (done pulses) regardless of finish.
- finish in same cycle as an accepted bundle: bundle enqueued, then DRAIN.
- finish in DRAIN/DONE/IDLE, start in LOAD/DRAIN: ignored.
- FIFO full with write stalled: in_ready low; no data lost.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err_* 0, words_written 0, state IDLE.
- Reset mid-write drops mem_we asynchronously; FIFO contents discarded.
- Latency: bundle accepted cycle N -> mem_we high at N+1 (FIFO empty, no pending write).
- Throughput: one word per cycle with mem_ready held high.
- mem_addr/mem_wdata stable while mem_we high and mem_ready low.
- done asserts the cycle after the last write completes (DRAIN) or after the overflow write completes.
- start accepted cycle N -> busy and in_ready high at N+1.

## Test plan
- start base 0x10; send ADD (OP 0x05, Rdest 3, Rsrc 7) -> mem_addr 0x10, mem_wdata 0x0357, words_written 1.
- ADDI (OP 0x50, Rdest 2, imm 0xFF), then Bcond (OP 0xC0, Rdest 0xE, imm 0x08) -> 0x52FF at 0x10, 0xCE08 at 0x11.
- STOR (OP 0x44, Rdest 9 addr, Rsrc 5) and LOAD (OP 0x40, Rdest 1, Rsrc 2) -> 0x4549, 0x4102.
- OP 0x80 bundle -> handshake completes, no mem_we, err_illegal 1; next valid bundle written at unchanged address.
- mem_ready low 10 cycles while 6 bundles offered -> in_ready drops after 4 accepted, mem_addr/wdata stable; release -> all 6 written in order, finish -> done pulse.
- ADDR_WIDTH 8, base 0xFE, 3 bundles -> writes at 0xFE, 0xFF, err_overflow 1, third word dropped, done pulse, words_written 2; reset mid-write -> mem_we 0 immediately.

Source files
------------

// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into 16-bit words and streams them to
// instruction memory through a small FIFO and a valid/ready write port.
module instruction_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            instructionOP,
    input  logic [3:0]            Rdest,
    input  logic [3:0]            Rsrc,
    input  logic [7:0]            immediate,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_illegal,
    output logic                  err_overflow,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [3:0]  hi, ext;
    logic [15:0] enc_word;
    logic        enc_legal;

    logic [15:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty;

    logic [ADDR_WIDTH-1:0] addr;
    logic accept, push, pop, wr_fire, ovf_hit, start_ok, flush;

    assign hi  = instructionOP[7:4];
    assign ext = instructionOP[3:0];

    // Inverse of the field decoder; STOR/JAL/Jcond carry the address in the
    // Rdest slot of the bundle but in the low nibble of the word.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        if (hi[1:0] != 2'b00) begin
            enc_word = {hi, Rdest, immediate};
        end else begin
            case (hi)
                4'b0000: enc_word = {4'b0000, Rdest, ext, Rsrc};
                4'b0100: begin
                    if (ext[3:2] == 2'b00)
                        enc_word = {4'b0100, Rdest, ext, Rsrc};
                    else
                        enc_word = {4'b0100, Rsrc, ext, Rdest};
                end
                4'b1100: enc_word = {4'b1100, Rdest, immediate};
                default: enc_legal = 1'b0;
            endcase
        end
    end

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    assign busy     = (state == S_LOAD) || (state == S_DRAIN);
    assign in_ready = (state == S_LOAD) && !fifo_full && !err_overflow;
    assign mem_we   = busy && !fifo_empty;
    assign mem_addr = addr;
    assign mem_wdata = mem_we ? fifo_mem[rd_ptr] : 16'h0000;

    assign accept   = in_valid && in_ready;
    assign push     = accept && enc_legal;
    assign wr_fire  = mem_we && mem_ready;
    assign pop      = wr_fire;
    assign ovf_hit  = wr_fire && (addr == TOP_ADDR);
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    // An overflow flush wins over a same-cycle push: that word has nowhere to go.
    assign flush    = start_ok || ovf_hit;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr          <= '0;
            words_written <= '0;
            err_illegal   <= 1'b0;
            err_overflow  <= 1'b0;
        end else if (start_ok) begin
            addr          <= base_addr;
            words_written <= '0;
            err_illegal   <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            if (wr_fire) begin
                words_written <= words_written + (ADDR_WIDTH+1)'(1);
                if (addr != TOP_ADDR)
                    addr <= addr + ADDR_WIDTH'(1);
            end
            if (accept && !enc_legal)
                err_illegal <= 1'b1;
            if (ovf_hit)
                err_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == S_DONE) && (state != S_DONE);
        end
    end

    // DRAIN finishes in the same cycle its last write completes so done
    // lands on the following cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_LOAD;
            end
            S_LOAD: begin
                if (ovf_hit)
                    state_next = S_DONE;
                else if (finish)
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (ovf_hit || fifo_empty || ((count == CW'(1)) && wr_fire))
                    state_next = S_DONE;
            end
            S_DONE: begin
                if (start)
                    state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
